// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared types and constants for the UART program loader
package uart_loader_pkg;

   // Parser states; CHK is only reached when LOADER_CHECKSUM_EN is defined
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LEN  = 2'd1,
      DATA = 2'd2,
      CHK  = 2'd3
   } state_t;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // Number of UART bytes that make up one instruction word
   function automatic int bytes_per_word(input int word_width, input int byte_width);
      return word_width / byte_width;
   endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - little-endian byte-lane assembler for instruction words
module loader_word_assembler
   import uart_loader_pkg::*;
#(
   parameter int BYTE_WIDTH = 8,
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  clear,
   input  logic                  byte_valid,
   input  logic [BYTE_WIDTH-1:0] byte_in,
   output logic [WORD_WIDTH-1:0] word_next,
   output logic                  word_done
);

   localparam int BPW    = bytes_per_word(WORD_WIDTH, BYTE_WIDTH);
   localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;

   logic [WORD_WIDTH-1:0] shift_q;
   logic [LANE_W-1:0]     lane_q;

   // Current partial word with the incoming byte dropped into its lane
   always_comb begin
      word_next = shift_q;
      for (int i = 0; i < BPW; i++) begin
         if (lane_q == LANE_W'(i)) begin
            word_next[i*BYTE_WIDTH +: BYTE_WIDTH] = byte_in;
         end
      end
   end

   assign word_done = byte_valid && (lane_q == LANE_W'(BPW - 1));

   // Accumulate lanes; the lane counter wraps to 0 after the final byte of a word
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         shift_q <= '0;
         lane_q  <= '0;
      end else if (clear) begin
         shift_q <= '0;
         lane_q  <= '0;
      end else if (byte_valid) begin
         shift_q <= word_next;
         lane_q  <= word_done ? '0 : lane_q + LANE_W'(1);
      end
   end

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - framed program loader from UART bytes into instruction memory (optional LOADER_CHECKSUM_EN)
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter int                    BYTE_WIDTH = 8,
   parameter int                    WORD_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [BYTE_WIDTH-1:0] SYNC_BYTE  = BYTE_WIDTH'(DEFAULT_SYNC_BYTE)
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  rx_done,
   input  logic [BYTE_WIDTH-1:0] data_in,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WORD_WIDTH-1:0] mem_wdata,
   output logic                  busy,
   output logic                  load_done,
   output logic                  load_error,
   output logic                  cpu_run
);

   state_t                state;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [ADDR_WIDTH-1:0] last_idx;
   logic                  asm_clear;
   logic                  asm_valid;
   logic                  word_done;
   logic [WORD_WIDTH-1:0] word_next;
`ifdef LOADER_CHECKSUM_EN
   logic [BYTE_WIDTH-1:0] acc;
`endif

   // The assembler restarts at LEN so a new frame always begins in lane 0
   assign asm_clear = rx_done && (state == LEN);
   assign asm_valid = rx_done && (state == DATA);

   loader_word_assembler #(
      .BYTE_WIDTH (BYTE_WIDTH),
      .WORD_WIDTH (WORD_WIDTH)
   ) u_asm (
      .clk        (clk),
      .arst_n     (arst_n),
      .clear      (asm_clear),
      .byte_valid (asm_valid),
      .byte_in    (data_in),
      .word_next  (word_next),
      .word_done  (word_done)
   );

   // Frame parser: all outputs registered; strobes default low every cycle
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state      <= IDLE;
         word_idx   <= '0;
         last_idx   <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
         load_done  <= 1'b0;
         load_error <= 1'b0;
         cpu_run    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         acc        <= '0;
`endif
      end else begin
         mem_we     <= 1'b0;
         load_done  <= 1'b0;
         load_error <= 1'b0;
         if (rx_done) begin
            case (state)
               IDLE: begin
                  if (data_in == SYNC_BYTE) begin
                     state   <= LEN;
                     busy    <= 1'b1;
                     cpu_run <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                     acc     <= '0;
`endif
                  end
               end
               LEN: begin
                  if (data_in == '0) begin
                     load_error <= 1'b1;
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     last_idx <= ADDR_WIDTH'(data_in) - ADDR_WIDTH'(1);
                     word_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                     acc      <= acc ^ data_in;
`endif
                     state    <= DATA;
                  end
               end
               DATA: begin
`ifdef LOADER_CHECKSUM_EN
                  acc <= acc ^ data_in;
`endif
                  if (word_done) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= word_idx;
                     mem_wdata <= word_next;
                     word_idx  <= word_idx + ADDR_WIDTH'(1);
                     if (word_idx == last_idx) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= CHK;
`else
                        load_done <= 1'b1;
                        cpu_run   <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
`endif
                     end
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               CHK: begin
                  if (data_in == acc) begin
                     load_done <= 1'b1;
                     cpu_run   <= 1'b1;
                  end else begin
                     load_error <= 1'b1;
                  end
                  busy  <= 1'b0;
                  state <= IDLE;
               end
`endif
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
